// File: rtl/time_entry_counter.sv
// Clocked HH:MM:SS time-entry counter: staged user entry, commit on run rising edge,
// free-running count advanced by an internal one-second prescaler, BCD digit outputs.
module time_entry_counter #(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned HOUR_MAX    = 24,
  parameter int unsigned VAL_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             wr,
  input  logic [VAL_W-1:0] val,
  input  logic             run,
  output logic [3:0]       hrs_tens,
  output logic [3:0]       hrs_ones,
  output logic [3:0]       min_tens,
  output logic [3:0]       min_ones,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones,
  output logic             tick,
  output logic             rollover
);

  localparam int unsigned PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [5:0]    LAST_MS  = 6'd59;
  localparam logic [5:0]    LAST_HR  = 6'(HOUR_MAX - 1);

  logic [5:0]    st_sec, st_min, st_hr;
  logic [5:0]    rn_sec, rn_min, rn_hr;
  logic [PW-1:0] pre;
  logic          run_q;
  logic          commit;
  logic [5:0]    val_ms, val_hr;
  logic [5:0]    disp_sec, disp_min, disp_hr;

  // Entry values clamped to the legal range of their field
  always_comb begin
    val_ms = (32'(val) > 32'd59) ? LAST_MS : 6'(val);
    val_hr = (32'(val) >= HOUR_MAX) ? LAST_HR : 6'(val);
  end

  assign commit = run & ~run_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_sec   <= '0;
      st_min   <= '0;
      st_hr    <= '0;
      rn_sec   <= '0;
      rn_min   <= '0;
      rn_hr    <= '0;
      pre      <= '0;
      run_q    <= 1'b0;
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else begin
      run_q    <= run;
      tick     <= 1'b0;
      rollover <= 1'b0;

      if (wr) begin
        case (mode)
          3'd1:    st_sec <= val_ms;
          3'd2:    st_min <= val_ms;
          3'd3:    st_hr  <= val_hr;
          default: ;
        endcase
      end

      // Commit loads the pre-write staging value; counting resumes next cycle
      if (commit) begin
        rn_sec <= st_sec;
        rn_min <= st_min;
        rn_hr  <= st_hr;
        pre    <= '0;
      end else if (run) begin
        if (pre == PRE_LAST) begin
          pre  <= '0;
          tick <= 1'b1;
          if (rn_sec == LAST_MS) begin
            rn_sec <= '0;
            if (rn_min == LAST_MS) begin
              rn_min <= '0;
              if (rn_hr == LAST_HR) begin
                rn_hr    <= '0;
                rollover <= 1'b1;
              end else begin
                rn_hr <= rn_hr + 6'd1;
              end
            end else begin
              rn_min <= rn_min + 6'd1;
            end
          end else begin
            rn_sec <= rn_sec + 6'd1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  // Show staging while held, running time while counting
  always_comb begin
    disp_sec = run_q ? rn_sec : st_sec;
    disp_min = run_q ? rn_min : st_min;
    disp_hr  = run_q ? rn_hr  : st_hr;
    hrs_tens = 4'(disp_hr  / 6'd10);
    hrs_ones = 4'(disp_hr  % 6'd10);
    min_tens = 4'(disp_min / 6'd10);
    min_ones = 4'(disp_min % 6'd10);
    sec_tens = 4'(disp_sec / 6'd10);
    sec_ones = 4'(disp_sec % 6'd10);
  end

endmodule

// File: tb/tb_time_entry_counter.sv
// Bench for time_entry_counter: 24 h and 12 h instances driven in lockstep and checked
// every cycle against a seconds-of-day reference model, plus directed scenario checks.
module tb_time_entry_counter;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset, wr, run;
  logic [2:0]  mode;
  logic [5:0]  val;
  logic [23:0] dig [2];
  logic [1:0]  tk, ro;

  int tests = 0;
  int fails = 0;

  int hmax [2] = '{24, 12};
  int st_h [2], st_m [2], st_s [2];
  int rt [2], pc [2];
  bit rq [2], etk [2], ero [2];

  always #5 clk = ~clk;

  time_entry_counter #(.TICK_CYCLES(T), .HOUR_MAX(24), .VAL_W(6)) u24 (
    .clk(clk), .reset(reset), .mode(mode), .wr(wr), .val(val), .run(run),
    .hrs_tens(dig[0][23:20]), .hrs_ones(dig[0][19:16]),
    .min_tens(dig[0][15:12]), .min_ones(dig[0][11:8]),
    .sec_tens(dig[0][7:4]),   .sec_ones(dig[0][3:0]),
    .tick(tk[0]), .rollover(ro[0])
  );

  time_entry_counter #(.TICK_CYCLES(T), .HOUR_MAX(12), .VAL_W(6)) u12 (
    .clk(clk), .reset(reset), .mode(mode), .wr(wr), .val(val), .run(run),
    .hrs_tens(dig[1][23:20]), .hrs_ones(dig[1][19:16]),
    .min_tens(dig[1][15:12]), .min_ones(dig[1][11:8]),
    .sec_tens(dig[1][7:4]),   .sec_ones(dig[1][3:0]),
    .tick(tk[1]), .rollover(ro[1])
  );

  function automatic logic [23:0] bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Reference: running time kept as seconds since midnight
  task automatic model(input int k);
    bit commit;
    if (reset) begin
      st_h[k] = 0; st_m[k] = 0; st_s[k] = 0;
      rt[k] = 0; pc[k] = 0; rq[k] = 0; etk[k] = 0; ero[k] = 0;
    end else begin
      etk[k] = 0;
      ero[k] = 0;
      commit = run && !rq[k];
      if (commit) begin
        rt[k] = st_h[k] * 3600 + st_m[k] * 60 + st_s[k];
        pc[k] = 0;
      end else if (run) begin
        if (pc[k] == T - 1) begin
          pc[k]  = 0;
          etk[k] = 1;
          rt[k]  = rt[k] + 1;
          if (rt[k] == hmax[k] * 3600) begin
            rt[k]  = 0;
            ero[k] = 1;
          end
        end else begin
          pc[k] = pc[k] + 1;
        end
      end
      if (wr) begin
        case (mode)
          3'd1:    st_s[k] = (int'(val) > 59) ? 59 : int'(val);
          3'd2:    st_m[k] = (int'(val) > 59) ? 59 : int'(val);
          3'd3:    st_h[k] = (int'(val) >= hmax[k]) ? hmax[k] - 1 : int'(val);
          default: ;
        endcase
      end
      rq[k] = run;
    end
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [2:0] md,
                      input logic [5:0] v, input logic ru);
    logic [23:0] exp;
    reset = r; wr = w; mode = md; val = v; run = ru;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp = rq[k] ? bcd(rt[k] / 3600, (rt[k] / 60) % 60, rt[k] % 60)
                  : bcd(st_h[k], st_m[k], st_s[k]);
      check($sformatf("digits[%0d] t=%0t", k, $time), dig[k], exp);
      check($sformatf("tick[%0d] t=%0t", k, $time), 24'(tk[k]), 24'(etk[k]));
      check($sformatf("rollover[%0d] t=%0t", k, $time), 24'(ro[k]), 24'(ero[k]));
    end
  endtask

  initial begin
    bit rl;
    reset = 1'b1; wr = 1'b0; mode = 3'd0; val = 6'd0; run = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_digits", dig[0], 24'h000000);

    // Entry and clamping
    step(0, 1, 1, 55, 0);
    step(0, 1, 2, 59, 0);
    step(0, 1, 3, 23, 0);
    check("entry_digits", dig[0], 24'h235955);
    step(0, 1, 1, 63, 0);
    step(0, 1, 3, 30, 0);
    check("clamp_digits", dig[0], 24'h235959);
    check("clamp_digits_12h", dig[1], 24'h115959);
    step(0, 1, 0, 10, 0);
    step(0, 1, 5, 10, 0);
    check("ignored_mode", dig[0], 24'h235959);

    // Commit 23:59:55, five ticks to rollover
    step(0, 1, 1, 55, 0);
    step(0, 0, 0, 0, 1);
    check("commit_digits", dig[0], 24'h235955);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    check("rollover_digits", dig[0], 24'h000000);
    check("rollover_pulse", 24'(ro[0]), 24'h1);
    step(0, 0, 0, 0, 1);
    check("rollover_cleared", 24'(ro[0]), 24'h0);

    // Hold and resume from staging 00:00:00
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    check("two_ticks", dig[0], 24'h000002);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    check("hold_shows_staging", dig[0], 24'h000000);
    step(0, 0, 0, 0, 1);
    check("recommit_discards", dig[0], 24'h000000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // 12 h wrap from 11:59:59
    step(0, 1, 3, 11, 0);
    step(0, 1, 2, 59, 0);
    step(0, 1, 1, 59, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    check("wrap12_digits", dig[1], 24'h000000);
    check("wrap12_rollover", 24'(ro[1]), 24'h1);
    step(0, 0, 0, 0, 0);

    // Reset while counting at 12:34:56
    step(0, 1, 3, 12, 0);
    step(0, 1, 2, 34, 0);
    step(0, 1, 1, 56, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("mid_reset_digits", dig[0], 24'h000000);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      check("no_tick_after_reset", 24'(tk[0]), 24'h0);
    end

    // Randomized traffic against the model
    rl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) rl = ~rl;
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), rl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
